// File: rtl/board_pkg.sv
// Shared types, constants and helpers for the board refresh engine and its peers.
package board_pkg;

    localparam int ROWS_DEF  = 8;
    localparam int COLS_DEF  = 8;
    localparam int CB_DEF    = 3;
    localparam int MAX_LANES = 64;

    typedef logic [CB_DEF-1:0] cell_t;

    localparam cell_t       EMPTY             = '0;
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;  // x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

    // Source lane for destination lane k when occupied lanes are packed toward
    // lane 0 in their original order; -1 means the destination is left empty.
    function automatic int pack_src(input logic [MAX_LANES-1:0] occ, input int k);
        int res;
        int seen;
        res  = -1;
        seen = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (occ[i]) begin
                if (seen == k) res = i;
                seen++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Seedable 16-bit Fibonacci LFSR with step enable; a zero seed falls back to the default.
module lfsr16 import board_pkg::*; #(
    parameter logic [15:0] SEED  = LFSR_DEFAULT_SEED,
    parameter int          OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [15:0]      load_val,
    input  logic             step,
    output logic [OUT_W-1:0] value
);

    localparam logic [15:0] RESET_VAL = (SEED == 16'h0) ? LFSR_DEFAULT_SEED : SEED;

    logic [15:0] state_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RESET_VAL;
        end else if (load) begin
            state_reg <= (load_val == 16'h0) ? LFSR_DEFAULT_SEED : load_val;
        end else if (step) begin
            state_reg <= {state_reg[14:0], ^(state_reg & LFSR_TAPS)};
        end
    end

    assign value = state_reg[OUT_W-1:0];

endmodule

// File: rtl/board_refresh_engine.sv
// Gravity drop, optional empty-column compaction and optional random refill of a
// match-3 board, run as a start/busy/done sequenced operation.
module board_refresh_engine import board_pkg::*; #(
    parameter int          ROWS       = ROWS_DEF,
    parameter int          COLS       = COLS_DEF,
    parameter int          CB         = CB_DEF,
    parameter int          NUM_COLORS = 7,
    parameter logic [15:0] SEED       = LFSR_DEFAULT_SEED
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [1:0]                         mode,
    input  logic [ROWS*COLS*CB-1:0]            board_in,
    input  logic                               seed_we,
    input  logic [15:0]                        seed_in,
    output logic                               busy,
    output logic                               done,
    output logic [ROWS*COLS*CB-1:0]            board_out,
    output logic [$clog2(ROWS*COLS+1)-1:0]     holes
);

    localparam int N  = ROWS * COLS;
    localparam int W  = N * CB;
    localparam int HW = $clog2(N + 1);
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_DROP, ST_SHIFT, ST_FILL, ST_DONE} state_t;

    state_t          state_reg;
    logic [1:0]      mode_reg;
    logic [CW-1:0]   col_cnt_reg;
    logic [NW-1:0]   cell_cnt_reg;
    logic [CB-1:0]   brd_reg  [N];
    logic [CB-1:0]   brd_next [N];
    logic [W-1:0]    brd_flat_next;
    logic [HW-1:0]   hole_cnt;
    logic [7:0]      rand_byte;
    logic            lfsr_step;
    logic [CB-1:0]   fill_val;
    logic            last_col;
    logic            last_cell;
    logic            enter_done;

    logic [MAX_LANES-1:0] drop_occ;
    logic [MAX_LANES-1:0] shift_occ;
    logic [CB-1:0]        drop_col  [ROWS];
    int                   drop_src  [ROWS];
    int                   shift_src [COLS];

    lfsr16 #(.SEED(SEED), .OUT_W(8)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (seed_we && !busy),
        .load_val (seed_in),
        .step     (lfsr_step),
        .value    (rand_byte)
    );

    // Drop works bottom-up so that "pack toward lane 0" lands pieces on row ROWS-1.
    always_comb begin
        drop_occ  = '0;
        shift_occ = '0;
        for (int i = 0; i < ROWS; i++) begin
            drop_col[i] = brd_reg[NW'(cell_idx(ROWS - 1 - i, int'(col_cnt_reg), COLS))];
            drop_occ[i] = (drop_col[i] != CB'(EMPTY));
        end
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (brd_reg[NW'(cell_idx(r, c, COLS))] != CB'(EMPTY)) shift_occ[c] = 1'b1;
            end
        end
        for (int i = 0; i < ROWS; i++) drop_src[i] = pack_src(drop_occ, i);
        for (int c = 0; c < COLS; c++) shift_src[c] = pack_src(shift_occ, c);
    end

    always_comb begin
        hole_cnt = '0;
        for (int i = 0; i < N; i++) begin
            if (board_in[i*CB +: CB] == CB'(EMPTY)) hole_cnt = hole_cnt + HW'(1);
        end
    end

    always_comb begin
        brd_next  = brd_reg;
        lfsr_step = 1'b0;
        fill_val  = CB'(int'(rand_byte) % NUM_COLORS + 1);
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    for (int i = 0; i < N; i++) brd_next[i] = board_in[i*CB +: CB];
                end
            end
            ST_DROP: begin
                for (int i = 0; i < ROWS; i++) begin
                    brd_next[NW'(cell_idx(ROWS - 1 - i, int'(col_cnt_reg), COLS))] =
                        (drop_src[i] >= 0) ? drop_col[RW'(drop_src[i])] : '0;
                end
            end
            ST_SHIFT: begin
                for (int c = 0; c < COLS; c++) begin
                    for (int r = 0; r < ROWS; r++) begin
                        brd_next[NW'(cell_idx(r, c, COLS))] = (shift_src[c] >= 0) ?
                            brd_reg[NW'(cell_idx(r, shift_src[c], COLS))] : '0;
                    end
                end
            end
            ST_FILL: begin
                if (brd_reg[cell_cnt_reg] == CB'(EMPTY)) begin
                    brd_next[cell_cnt_reg] = fill_val;
                    lfsr_step              = 1'b1;
                end
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_flat
        assign brd_flat_next[gi*CB +: CB] = brd_next[gi];
    end

    assign last_col   = (col_cnt_reg == CW'(COLS - 1));
    assign last_cell  = (cell_cnt_reg == NW'(N - 1));
    // board_out is loaded from the final next-state so it is valid in the DONE cycle itself.
    assign enter_done = (state_reg == ST_DROP && last_col && mode_reg == 2'b00) ||
                        (state_reg == ST_SHIFT && !mode_reg[1]) ||
                        (state_reg == ST_FILL && last_cell);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            mode_reg     <= '0;
            col_cnt_reg  <= '0;
            cell_cnt_reg <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            board_out    <= '0;
            holes        <= '0;
            for (int i = 0; i < N; i++) brd_reg[i] <= '0;
        end else begin
            brd_reg <= brd_next;
            done    <= 1'b0;
            if (enter_done) begin
                done      <= 1'b1;
                board_out <= brd_flat_next;
                state_reg <= ST_DONE;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        mode_reg     <= mode;
                        holes        <= hole_cnt;
                        col_cnt_reg  <= '0;
                        cell_cnt_reg <= '0;
                        busy         <= 1'b1;
                        state_reg    <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (last_col) begin
                        col_cnt_reg <= '0;
                        if (mode_reg[0])      state_reg <= ST_SHIFT;
                        else if (mode_reg[1]) state_reg <= ST_FILL;
                    end else begin
                        col_cnt_reg <= col_cnt_reg + CW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (mode_reg[1]) state_reg <= ST_FILL;
                end
                ST_FILL: begin
                    cell_cnt_reg <= last_cell ? '0 : cell_cnt_reg + NW'(1);
                end
                ST_DONE: begin
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/board_refresh_engine.md
Name: board_refresh_engine

Overview:
- Sequential gravity/compaction/refill engine for the match-3 board, parametrised in board size, colour depth and colour count.
- After the match-detect stage zeroes eliminated cells, this block processes the board in three steps:
  - drops pieces down each column;
  - optionally compacts empty columns to the left;
  - optionally refills holes with pseudo-random colours from an internal, seedable LFSR.
- It sits between match detection and the display/board register, and uses a start/busy/done handshake.

Parameters:
- ROWS, 8, board rows (row 0 = top).
- COLS, 8, board columns (col 0 = left).
- CB, 3, bits per cell. Value 0 = empty; any non-zero value is a piece.
- NUM_COLORS, 7, refill colour range 1..NUM_COLORS. Requires NUM_COLORS <= 2^CB-1.
- SEED, 16'hACE1, LFSR reset value. SEED=0 is replaced by 16'hACE1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse. Accepted only when busy=0.
- mode  in  2  bit0 = column left-shift enable, bit1 = refill enable. Latched at start.
- board_in  in  ROWS*COLS*CB  board snapshot. Cell (r,c) is at [((r*COLS)+c)*CB +: CB]. Latched at start.
- seed_we  in  1  load seed_in into the LFSR. Honoured only when busy=0.
- seed_in  in  16  new seed. 0 is replaced by 16'hACE1.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse in DONE. board_out and holes are valid from this cycle.
- board_out  out  ROWS*COLS*CB  result board. Same layout as board_in. Held until the next DONE.
- holes  out  $clog2(ROWS*COLS+1)  number of empty cells in the latched input.

Behaviour:
- Reset values:
  - busy=0, done=0, board_out=0, holes=0.
  - FSM=IDLE, internal board=0, column counter=0, cell counter=0.
  - LFSR=SEED.
- FSM states: IDLE, DROP, SHIFT, FILL, DONE.
- IDLE:
  - start=1 in cycle T latches board_in and mode, computes holes, clears counters, goes to DROP.
  - If seed_we and start are both high, the seed is loaded first and start is also accepted.
- DROP:
  - One column per cycle, col 0..COLS-1.
  - Non-zero cells are packed toward row ROWS-1, preserving their relative order; zeros fill the top.
  - After the last column: go to SHIFT if mode[0], else FILL if mode[1], else DONE.
- SHIFT (1 cycle):
  - Columns that are all-zero are removed.
  - Non-empty columns keep their order, packed to col 0; all-zero columns fill the right.
  - Then go to FILL if mode[1], else DONE.
- FILL:
  - Visits every cell row-major, one per cycle, ROWS*COLS cycles.
  - An empty cell gets 1 + (lfsr[7:0] % NUM_COLORS), and the LFSR steps once.
  - A non-empty cell is left unchanged and the LFSR holds.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts left with feedback into bit 0.
  - Steps only in FILL on empty cells.
- DONE (1 cycle): board_out <= internal board, done=1, busy=1. Next state IDLE.
- Latency:
  - done asserts at T + COLS + mode[0] + mode[1]*ROWS*COLS + 1.
  - For 8x8: mode 0 → T+9; mode 1 → T+10; mode 2 → T+73; mode 3 → T+74.
- start or seed_we while busy is ignored, with no side effect.
- Asynchronous reset mid-operation aborts immediately to reset values. The partial result is discarded.
- All-empty board:
  - With mode 1, output is all zero.
  - With mode 2, output is fully refilled and holes = ROWS*COLS.
- Full board (no zeros): output equals input; the LFSR does not step; holes = 0.
- Cell values above NUM_COLORS are treated as ordinary pieces and preserved.

Decomposition:
- Shared package board_pkg holds:
  - ROWS/COLS/CB defaults;
  - the cell_t typedef (logic [CB-1:0]);
  - the EMPTY = 0 constant;
  - the LFSR tap constant;
  - the cell index function (r*COLS+c).
- One natural sub-module, lfsr16: seed load, step enable, 16-bit state output. It is reusable for other random events in the game.
- Column packing is a combinational function in the package, shared by DROP and SHIFT.

Test Plan:
- 8x8, mode 0. Col 3 = top→bottom {1,2,0,3,0,4,5,0}; all other cells 7. → done at T+9. Col 3 = {0,0,0,1,2,3,4,5}. holes=3. Other columns unchanged.
- 8x8, mode 1. Cols 2 and 5 all zero; col c otherwise = c+1 in every row. → col0..5 = values 1,2,4,5,7,8 (8 fits CB=3? no — use CB=4 in this test). Cols 6,7 zero. done at T+10.
- mode 2, all-zero board, seed 16'hACE1 → done at T+73. Every cell is in 1..7 and matches the reference LFSR model in row-major order. holes=64.
- mode 2, full board of 1s → output equals input. LFSR state unchanged (verified by a following run). done at T+73.
- start pulsed at T+5 during busy, and seed_we during busy → both ignored. Result and latency match a run without them.
- rst asserted at T+30 of a mode 3 run → busy, done and board_out are 0 immediately; LFSR = SEED. A new start then completes normally at +74.
